// File: rtl/cpu_pkg.sv
// Shared core-wide constants for the 8-bit dual-issue pipeline.
// The write-back stage imports this package now. The MEM/WB register and
// decode will import it later.
package cpu_pkg;

    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;

    // r0 is architecturally hardwired to zero.
    localparam logic [ADDR_W-1:0] R0_ADDR = '0;

endpackage : cpu_pkg

// File: rtl/wb_read_port.sv
// One architectural read port with write-through bypass.
// Lane 2 is later in program order than lane 1, so a lane-2 hit has priority.
// r0 always reads as zero, whatever sits in storage or on the bypass lanes.
module wb_read_port
    import cpu_pkg::*;
#(
    parameter int PORT_DATA_W = DATA_W,
    parameter int PORT_ADDR_W = ADDR_W
) (
    input  logic [PORT_ADDR_W-1:0] addr_i,
    input  logic [PORT_DATA_W-1:0] regData_i,
    input  logic                   we1_i,
    input  logic [PORT_ADDR_W-1:0] rd1_i,
    input  logic [PORT_DATA_W-1:0] wbData1_i,
    input  logic                   we2_i,
    input  logic [PORT_ADDR_W-1:0] rd2_i,
    input  logic [PORT_DATA_W-1:0] wbData2_i,
    output logic [PORT_DATA_W-1:0] rdata_o
);

    // Bypass priority: r0 first, then the younger lane 2, then lane 1, then storage.
    always_comb begin
        rdata_o = regData_i;
        if (addr_i == PORT_ADDR_W'(R0_ADDR)) begin
            rdata_o = '0;
        end else if (we2_i && (rd2_i == addr_i)) begin
            rdata_o = wbData2_i;
        end else if (we1_i && (rd1_i == addr_i)) begin
            rdata_o = wbData1_i;
        end
    end

endmodule : wb_read_port

// File: rtl/wb_regfile.sv
// Write-back stage and 32 x 8 architectural register file of the dual-issue core.
// Selects memory or ALU data per lane and commits up to two results per cycle.
// It serves four combinational, write-through read ports to decode.
// It also keeps a retire counter and a one-cycle same-destination collision flag.
module wb_regfile #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] readdata_1,
    input  logic [DATA_W-1:0] resultalu_1,
    input  logic [ADDR_W-1:0] rd_1,
    input  logic              memtoreg_1,
    input  logic              regwrite_1,
    input  logic [DATA_W-1:0] readdata_2,
    input  logic [DATA_W-1:0] resultalu_2,
    input  logic [ADDR_W-1:0] rd_2,
    input  logic              memtoreg_2,
    input  logic              regwrite_2,
    input  logic [ADDR_W-1:0] rs1_a,
    input  logic [ADDR_W-1:0] rs2_a,
    input  logic [ADDR_W-1:0] rs1_b,
    input  logic [ADDR_W-1:0] rs2_b,
    output logic [DATA_W-1:0] rdata1_a,
    output logic [DATA_W-1:0] rdata2_a,
    output logic [DATA_W-1:0] rdata1_b,
    output logic [DATA_W-1:0] rdata2_b,
    output logic [DATA_W-1:0] wb_data_1,
    output logic [DATA_W-1:0] wb_data_2,
    output logic              wb_conflict,
    output logic [CNT_W-1:0]  retire_count
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regFile_q [NUM_REGS];
    logic              weLane1;
    logic              weLane2;
    logic              collision;
    logic [CNT_W-1:0]  retireCount_q;
    logic [CNT_W-1:0]  retireCount_d;
    logic              conflict_q;
    logic              conflict_d;

    // Per-lane result mux. It does not depend on regwrite, so it can feed forwarding paths.
    assign wb_data_1 = memtoreg_1 ? readdata_1 : resultalu_1;
    assign wb_data_2 = memtoreg_2 ? readdata_2 : resultalu_2;

    // A write to r0 is not a real write. It neither commits nor retires.
    assign weLane1   = regwrite_1 && (rd_1 != ADDR_W'(cpu_pkg::R0_ADDR));
    assign weLane2   = regwrite_2 && (rd_2 != ADDR_W'(cpu_pkg::R0_ADDR));
    assign collision = weLane1 && weLane2 && (rd_1 == rd_2);

    // Next-state for the bookkeeping registers. A collision still retires two instructions.
    always_comb begin
        retireCount_d = retireCount_q + CNT_W'(weLane1) + CNT_W'(weLane2);
        conflict_d    = collision;
    end

    // Register storage. On a collision the younger lane-2 result wins; writes are dropped during reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regFile_q[i] <= '0;
            end
        end else begin
            if (weLane1 && !collision) begin
                regFile_q[rd_1] <= wb_data_1;
            end
            if (weLane2) begin
                regFile_q[rd_2] <= wb_data_2;
            end
        end
    end

    // Retire counter wraps freely. The conflict flag marks only the cycle after a collision.
    always_ff @(posedge clk) begin
        if (!reset) begin
            retireCount_q <= '0;
            conflict_q    <= 1'b0;
        end else begin
            retireCount_q <= retireCount_d;
            conflict_q    <= conflict_d;
        end
    end

    assign retire_count = retireCount_q;
    assign wb_conflict  = conflict_q;

    wb_read_port #(.PORT_DATA_W(DATA_W), .PORT_ADDR_W(ADDR_W)) u_readPort1a (
        .addr_i(rs1_a), .regData_i(regFile_q[rs1_a]),
        .we1_i(weLane1), .rd1_i(rd_1), .wbData1_i(wb_data_1),
        .we2_i(weLane2), .rd2_i(rd_2), .wbData2_i(wb_data_2),
        .rdata_o(rdata1_a)
    );

    wb_read_port #(.PORT_DATA_W(DATA_W), .PORT_ADDR_W(ADDR_W)) u_readPort2a (
        .addr_i(rs2_a), .regData_i(regFile_q[rs2_a]),
        .we1_i(weLane1), .rd1_i(rd_1), .wbData1_i(wb_data_1),
        .we2_i(weLane2), .rd2_i(rd_2), .wbData2_i(wb_data_2),
        .rdata_o(rdata2_a)
    );

    wb_read_port #(.PORT_DATA_W(DATA_W), .PORT_ADDR_W(ADDR_W)) u_readPort1b (
        .addr_i(rs1_b), .regData_i(regFile_q[rs1_b]),
        .we1_i(weLane1), .rd1_i(rd_1), .wbData1_i(wb_data_1),
        .we2_i(weLane2), .rd2_i(rd_2), .wbData2_i(wb_data_2),
        .rdata_o(rdata1_b)
    );

    wb_read_port #(.PORT_DATA_W(DATA_W), .PORT_ADDR_W(ADDR_W)) u_readPort2b (
        .addr_i(rs2_b), .regData_i(regFile_q[rs2_b]),
        .we1_i(weLane1), .rd1_i(rd_1), .wbData1_i(wb_data_1),
        .we2_i(weLane2), .rd2_i(rd_2), .wbData2_i(wb_data_2),
        .rdata_o(rdata2_b)
    );

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile.
// Each table vector drives one cycle of both write-back lanes and four read addresses.
// Its expected outputs are queued when it is driven and compared mid-cycle.
// Hand-written sequences cover counter wrap and reset in the middle of a write.
module tb_wb_regfile;

    typedef struct packed {
        logic [4:0]      rd1;
        logic [7:0]      rdat1;
        logic [7:0]      alu1;
        logic            mem1;
        logic            rw1;
        logic [4:0]      rd2;
        logic [7:0]      rdat2;
        logic [7:0]      alu2;
        logic            mem2;
        logic            rw2;
        logic [3:0][4:0] rs;
        logic [3:0][7:0] expRd;
        logic [7:0]      expWb1;
        logic [7:0]      expWb2;
        logic [15:0]     expCnt;
        logic            expConf;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  readdata_1, resultalu_1, readdata_2, resultalu_2;
    logic [4:0]  rd_1, rd_2, rs1_a, rs2_a, rs1_b, rs2_b;
    logic        memtoreg_1, regwrite_1, memtoreg_2, regwrite_2;
    logic [7:0]  rdata1_a, rdata2_a, rdata1_b, rdata2_b, wb_data_1, wb_data_2;
    logic        wb_conflict;
    logic [15:0] retire_count;

    int   checks   = 0;
    int   failures = 0;
    vec_t expQ[$];
    vec_t tbl[17];

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk(clk), .reset(reset),
        .readdata_1(readdata_1), .resultalu_1(resultalu_1), .rd_1(rd_1),
        .memtoreg_1(memtoreg_1), .regwrite_1(regwrite_1),
        .readdata_2(readdata_2), .resultalu_2(resultalu_2), .rd_2(rd_2),
        .memtoreg_2(memtoreg_2), .regwrite_2(regwrite_2),
        .rs1_a(rs1_a), .rs2_a(rs2_a), .rs1_b(rs1_b), .rs2_b(rs2_b),
        .rdata1_a(rdata1_a), .rdata2_a(rdata2_a), .rdata1_b(rdata1_b), .rdata2_b(rdata2_b),
        .wb_data_1(wb_data_1), .wb_data_2(wb_data_2),
        .wb_conflict(wb_conflict), .retire_count(retire_count)
    );

    // One comparison: count it and report any difference.
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Build one table record from its inputs and hand-computed expectations.
    function automatic vec_t mk(
        input logic [4:0] rd1, input logic [7:0] rdat1, input logic [7:0] alu1,
        input logic mem1, input logic rw1,
        input logic [4:0] rd2, input logic [7:0] rdat2, input logic [7:0] alu2,
        input logic mem2, input logic rw2,
        input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3,
        input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3,
        input logic [7:0] w1, input logic [7:0] w2, input logic [15:0] cnt, input logic conf);
        vec_t v;
        v.rd1 = rd1; v.rdat1 = rdat1; v.alu1 = alu1; v.mem1 = mem1; v.rw1 = rw1;
        v.rd2 = rd2; v.rdat2 = rdat2; v.alu2 = alu2; v.mem2 = mem2; v.rw2 = rw2;
        v.rs[0] = a0; v.rs[1] = a1; v.rs[2] = a2; v.rs[3] = a3;
        v.expRd[0] = e0; v.expRd[1] = e1; v.expRd[2] = e2; v.expRd[3] = e3;
        v.expWb1 = w1; v.expWb2 = w2; v.expCnt = cnt; v.expConf = conf;
        return v;
    endfunction

    // Drive one cycle of lane inputs and read addresses.
    task automatic driveLanes(input vec_t v);
        rd_1 = v.rd1; readdata_1 = v.rdat1; resultalu_1 = v.alu1; memtoreg_1 = v.mem1; regwrite_1 = v.rw1;
        rd_2 = v.rd2; readdata_2 = v.rdat2; resultalu_2 = v.alu2; memtoreg_2 = v.mem2; regwrite_2 = v.rw2;
        rs1_a = v.rs[0]; rs2_a = v.rs[1]; rs1_b = v.rs[2]; rs2_b = v.rs[3];
    endtask

    // Drive a vector and queue its expected outputs.
    task automatic applyStimulus(input vec_t v);
        driveLanes(v);
        expQ.push_back(v);
    endtask

    // Pop the oldest expectation and compare every output against it.
    task automatic checkOutput(input int idx);
        vec_t v;
        if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard_empty vec=%0d actual=0 required=1", idx);
        end else begin
            v = expQ.pop_front();
            check($sformatf("v%0d rdata1_a", idx), 16'(rdata1_a), 16'(v.expRd[0]));
            check($sformatf("v%0d rdata2_a", idx), 16'(rdata2_a), 16'(v.expRd[1]));
            check($sformatf("v%0d rdata1_b", idx), 16'(rdata1_b), 16'(v.expRd[2]));
            check($sformatf("v%0d rdata2_b", idx), 16'(rdata2_b), 16'(v.expRd[3]));
            check($sformatf("v%0d wb_data_1", idx), 16'(wb_data_1), 16'(v.expWb1));
            check($sformatf("v%0d wb_data_2", idx), 16'(wb_data_2), 16'(v.expWb2));
            check($sformatf("v%0d retire_count", idx), retire_count, v.expCnt);
            check($sformatf("v%0d wb_conflict", idx), 16'(wb_conflict), 16'(v.expConf));
        end
    endtask

    // Apply one vector at posedge+1, compare at the next negedge, and step to posedge+1.
    task automatic runVector(input vec_t v, input int idx);
        applyStimulus(v);
        @(negedge clk);
        checkOutput(idx);
        @(posedge clk);
        #1;
    endtask

    vec_t idleV;

    // Watchdog so the bench always ends even if the stimulus stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence.
    initial begin
        idleV = mk(0,8'h00,8'h00,0,0, 0,8'h00,8'h00,0,0, 0,0,0,0, 8'h00,8'h00,8'h00,8'h00, 8'h00,8'h00, 16'd0,0);

        //        rd1  rdat1  alu1  m w  rd2  rdat2  alu2  m w  rs1a rs2a rs1b rs2b  exp reads                 wb1    wb2    cnt  cf
        tbl[0]  = mk(3,8'hEE,8'h5A,0,1, 7,8'hC3,8'h44,1,1, 3,7,0,1,     8'h5A,8'hC3,8'h00,8'h00, 8'h5A,8'hC3, 16'd0,0);
        tbl[1]  = mk(3,8'hEE,8'hAB,0,0, 7,8'h12,8'h34,0,0, 3,7,7,3,     8'h5A,8'hC3,8'hC3,8'h5A, 8'hAB,8'h34, 16'd2,0);
        tbl[2]  = mk(9,8'h01,8'h11,0,1, 9,8'h02,8'h22,0,1, 9,9,3,0,     8'h22,8'h22,8'h5A,8'h00, 8'h11,8'h22, 16'd2,0);
        tbl[3]  = mk(0,8'h00,8'h00,0,0, 0,8'h00,8'h00,0,0, 9,3,7,9,     8'h22,8'h5A,8'hC3,8'h22, 8'h00,8'h00, 16'd4,1);
        tbl[4]  = mk(0,8'h00,8'h00,0,0, 0,8'h00,8'h00,0,0, 9,9,9,9,     8'h22,8'h22,8'h22,8'h22, 8'h00,8'h00, 16'd4,0);
        tbl[5]  = mk(0,8'h00,8'hFF,0,1, 0,8'h00,8'h00,0,0, 0,0,9,0,     8'h00,8'h00,8'h22,8'h00, 8'hFF,8'h00, 16'd4,0);
        tbl[6]  = mk(0,8'h00,8'h00,0,0, 0,8'h00,8'h00,0,0, 0,0,0,0,     8'h00,8'h00,8'h00,8'h00, 8'h00,8'h00, 16'd4,0);
        tbl[7]  = mk(4,8'h00,8'h10,0,1, 0,8'h00,8'h00,0,0, 4,4,0,9,     8'h10,8'h10,8'h00,8'h22, 8'h10,8'h00, 16'd4,0);
        tbl[8]  = mk(0,8'h00,8'h00,0,0, 0,8'h00,8'h00,0,0, 4,4,4,4,     8'h10,8'h10,8'h10,8'h10, 8'h00,8'h00, 16'd5,0);
        tbl[9]  = mk(4,8'h00,8'h99,0,0, 0,8'h00,8'h00,0,0, 4,4,4,4,     8'h10,8'h10,8'h10,8'h10, 8'h99,8'h00, 16'd5,0);
        tbl[10] = mk(4,8'h00,8'h99,0,0, 0,8'h00,8'h00,0,0, 4,4,4,4,     8'h10,8'h10,8'h10,8'h10, 8'h99,8'h00, 16'd5,0);
        tbl[11] = mk(4,8'h00,8'h99,0,1, 0,8'h00,8'h00,0,0, 4,4,4,4,     8'h99,8'h99,8'h99,8'h99, 8'h99,8'h00, 16'd5,0);
        tbl[12] = mk(0,8'h00,8'h00,0,0, 0,8'h00,8'h00,0,0, 4,4,4,4,     8'h99,8'h99,8'h99,8'h99, 8'h00,8'h00, 16'd6,0);
        tbl[13] = mk(10,8'h3C,8'h77,1,1, 11,8'hAA,8'h55,0,0, 10,11,4,10, 8'h3C,8'h00,8'h99,8'h3C, 8'h3C,8'h55, 16'd6,0);
        tbl[14] = mk(4,8'h00,8'h88,0,0, 4,8'h00,8'h01,0,1, 4,10,4,11,   8'h01,8'h3C,8'h01,8'h00, 8'h88,8'h01, 16'd7,0);
        tbl[15] = mk(12,8'h00,8'h21,0,1, 0,8'h00,8'h99,0,1, 12,0,4,0,   8'h21,8'h00,8'h01,8'h00, 8'h21,8'h99, 16'd8,0);
        tbl[16] = mk(0,8'h00,8'h00,0,0, 0,8'h00,8'h00,0,0, 12,0,10,4,   8'h21,8'h00,8'h3C,8'h01, 8'h00,8'h00, 16'd9,0);

        // Reset held for two edges with idle lanes.
        reset = 1'b0;
        driveLanes(idleV);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // After reset, every register reads zero, four addresses per cycle.
        for (int k = 0; k < 8; k++) begin
            vec_t v;
            v = idleV;
            v.rs[0] = 5'(4 * k);
            v.rs[1] = 5'(4 * k + 1);
            v.rs[2] = 5'(4 * k + 2);
            v.rs[3] = 5'(4 * k + 3);
            runVector(v, 100 + k);
        end

        // Table-driven main sequence.
        for (int i = 0; i < 17; i++) begin
            runVector(tbl[i], i);
        end

        // Counter wrap: from reset, 32767 dual writes plus one single write give 0xFFFF.
        reset = 1'b0;
        driveLanes(idleV);
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 32767; i++) begin
            rd_1 = 5'd1; resultalu_1 = 8'(i); memtoreg_1 = 1'b0; regwrite_1 = 1'b1;
            rd_2 = 5'd2; resultalu_2 = 8'(i + 1); memtoreg_2 = 1'b0; regwrite_2 = 1'b1;
            @(posedge clk);
            #1;
        end
        driveLanes(idleV);
        rd_1 = 5'd1; regwrite_1 = 1'b1;
        @(posedge clk);
        #1;
        driveLanes(idleV);
        @(negedge clk);
        check("wrap count_ffff", retire_count, 16'hFFFF);
        check("wrap conflict_clear", 16'(wb_conflict), 16'h0000);
        @(posedge clk);
        #1;
        rd_2 = 5'd3; regwrite_2 = 1'b1;
        @(posedge clk);
        #1;
        driveLanes(idleV);
        @(negedge clk);
        check("wrap count_zero", retire_count, 16'h0000);

        // Reset mid-stream during a colliding write to r5. The write and the collision must vanish.
        @(posedge clk);
        #1;
        reset = 1'b0;
        rd_1 = 5'd5; resultalu_1 = 8'h77; memtoreg_1 = 1'b0; regwrite_1 = 1'b1;
        rd_2 = 5'd5; resultalu_2 = 8'h66; memtoreg_2 = 1'b0; regwrite_2 = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        driveLanes(idleV);
        rs1_a = 5'd5; rs2_b = 5'd1;
        @(negedge clk);
        check("midreset r5", 16'(rdata1_a), 16'h0000);
        check("midreset r1", 16'(rdata2_b), 16'h0000);
        check("midreset count", retire_count, 16'h0000);
        check("midreset conflict", 16'(wb_conflict), 16'h0000);

        // The first write after reset commits normally.
        @(posedge clk);
        #1;
        rd_1 = 5'd5; readdata_1 = 8'h33; resultalu_1 = 8'h44; memtoreg_1 = 1'b1; regwrite_1 = 1'b1;
        @(negedge clk);
        check("postreset bypass r5", 16'(rdata1_a), 16'h0033);
        @(posedge clk);
        #1;
        driveLanes(idleV);
        rs1_a = 5'd5;
        @(negedge clk);
        check("postreset stored r5", 16'(rdata1_a), 16'h0033);
        check("postreset count", retire_count, 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_wb_regfile
